mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit feeding the Hi/Lo registers: 35-cycle fixed latency, abortable.
// Optional feature macro: MDU_DIV_EN compiles in DIVU/DIV; without it divide requests are ignored.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  output logic             busy,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int DW = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             neg_lo_q, neg_lo_d;
  logic             accept_s;
  logic             rs_neg_s, rt_neg_s;
  logic [WIDTH-1:0] rs_mag_s, rt_mag_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [DW-1:0]    mul_step_s, prod_s, step_s;
  logic [WIDTH-1:0] fix_hi_s, fix_lo_s;

  assign rs_neg_s = signed_q & rs_q[WIDTH-1];
  assign rt_neg_s = signed_q & rt_q[WIDTH-1];
  assign rs_mag_s = rs_neg_s ? -rs_q : rs_q;
  assign rt_mag_s = rt_neg_s ? -rt_q : rt_q;

  // Shift-add: acc holds {partial product, remaining multiplier bits}
  assign mul_sum_s  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign mul_step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
  assign prod_s     = neg_lo_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH:0]   div_shift_s, div_diff_s;
  logic [DW-1:0]    div_step_s;
  logic [WIDTH-1:0] quot_s, rem_s;

  assign accept_s = start;

  // Restoring divide: acc holds {partial remainder, dividend bits shifting into quotient}
  assign div_shift_s = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, mcand_q};
  assign div_step_s  = div_diff_s[WIDTH] ? {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                         : {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quot_s = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_s  = neg_hi_q ? -acc_q[DW-1:WIDTH] : acc_q[DW-1:WIDTH];

  assign step_s   = is_div_q ? div_step_s : mul_step_s;
  assign fix_lo_s = !is_div_q ? prod_s[WIDTH-1:0] :
                    (mcand_q == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} : quot_s;
  assign fix_hi_s = !is_div_q ? prod_s[DW-1:WIDTH] :
                    (mcand_q == {WIDTH{1'b0}}) ? rs_q : rem_s;
`else
  assign accept_s = start & ~op[1];
  assign step_s   = mul_step_s;
  assign fix_lo_s = prod_s[WIDTH-1:0];
  assign fix_hi_s = prod_s[DW-1:WIDTH];
`endif

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d  = PREP;
          signed_d = op[0];
          rs_d     = rs_val;
          rt_d     = rt_val;
`ifdef MDU_DIV_EN
          is_div_d = op[1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d  = RUN;
          acc_d    = {{WIDTH{1'b0}}, rs_mag_s};
          mcand_d  = rt_mag_s;
          neg_lo_d = rs_neg_s ^ rt_neg_s;
          cnt_d    = 5'd0;
`ifdef MDU_DIV_EN
          neg_hi_d = rs_neg_s;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d = step_s;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = FIX;
          end else begin
            state_d = RUN;
          end
        end
      end
      FIX: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          hi_d    = fix_hi_s;
          lo_d    = fix_lo_s;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      signed_q <= 1'b0;
      rs_q     <= {WIDTH{1'b0}};
      rt_q     <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      acc_q    <= {DW{1'b0}};
      cnt_q    <= 5'd0;
      neg_lo_q <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  // A flush arriving during DONE must kill the write in that same cycle
  assign busy   = (state_q != IDLE);
  assign hi_we  = (state_q == DONE) & ~abort;
  assign lo_we  = (state_q == DONE) & ~abort;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random and directed ops against an arithmetic reference model.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] last_res = 64'd0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .abort(abort), .busy(busy), .hi_we(hi_we), .lo_we(lo_we), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain integer arithmetic, result as {hi, lo}
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint xa, xb, q, r;
    logic [63:0] ua, ub;
    xa = longint'($signed(a));
    xb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: return ua * ub;
      2'b01: return 64'(xa * xb);
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        else return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = xa / xb;
        r = xa % xb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input bit with_abort, output int c);
    bit acc;
    logic [63:0] r;
    exp_t e;
    wait_idle();
    start = 1'b1; op = o; rs_val = a; rt_val = b; abort = with_abort;
    c = cyc;
    acc = !o[1] || DIV_EN;
    if (acc && push) begin
      r = ref_model(o, a, b);
      e.hi = r[63:32]; e.lo = r[31:0]; e.cyc = c + 35;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    rs_val = $urandom; rt_val = $urandom; op = 2'($urandom);
    if (acc) chk("busy_accepted", 64'(busy), 64'd1);
    else     chk("busy_ignored", 64'(busy), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    wait_idle();
  endtask

  // Monitor: pop and compare on every write pulse, otherwise outputs must hold
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("we_pair", 64'(hi_we), 64'(lo_we));
      if (hi_we) begin
        if (sbq.size() == 0) begin
          chk("spurious_we", 64'(hi_we), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("hi_out", 64'(hi_out), 64'(e.hi));
          chk("lo_out", 64'(lo_out), 64'(e.lo));
          chk("latency", 64'(cyc), 64'(e.cyc));
          last_res = {e.hi, e.lo};
        end
      end else begin
        chk("hold", {hi_out, lo_out}, last_res);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [1:0] o;
    logic [31:0] a, b;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", {62'd0, hi_we, lo_we}, 64'd0);
    chk("rst_out", {hi_out, lo_out}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 64'(busy), 64'd0);

    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, c); drain();
    issue(2'b01, 32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b1, c); drain();
    issue(2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b0, c); drain();
    issue(2'b10, 32'd100, 32'd0, 1'b1, 1'b0, c); drain();
    issue(2'b11, 32'hFFFFFF9C, 32'd0, 1'b1, 1'b0, c); drain();
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, c); drain();
    issue(2'b11, 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, c); drain();

    // Second start at E5 must be ignored; busy spans E0..E35
    issue(2'b01, 32'h12345678, 32'hFEDCBA98, 1'b1, 1'b0, c);
    while (cyc < c + 37) begin
      @(negedge clk);
      chk("busy_window", 64'(busy), 64'(cyc >= c + 1 && cyc <= c + 35));
      @(posedge clk); #1;
      start = (cyc == c + 5);
      if (start) begin
        op = 2'b00; rs_val = 32'h0000FFFF; rt_val = 32'h00000003;
      end
    end
    start = 1'b0;
    drain();

    // Abort in RUN cycle 10, then immediate restart
    issue(2'b01, rnd32(), rnd32(), 1'b0, 1'b0, c);
    while (cyc < c + 11) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    issue(2'b00, 32'hDEADBEEF, 32'h00010001, 1'b1, 1'b0, c); drain();

    // Abort sampled in DONE suppresses the write
    a = 32'h00000123; b = 32'h00000456;
    issue(2'b00, a, b, 1'b0, 1'b0, c);
    while (cyc < c + 35) begin @(posedge clk); #1; end
    abort = 1'b1;
    last_res = ref_model(2'b00, a, b);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_done_busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-RUN
    issue(2'b01, rnd32(), rnd32(), 1'b0, 1'b0, c);
    while (cyc < c + 15) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_we", {62'd0, hi_we, lo_we}, 64'd0);
    chk("async_rst_out", {hi_out, lo_out}, 64'd0);
    last_res = 64'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(2'b01, 32'h80000000, 32'h80000000, 1'b1, 1'b0, c); drain();

    // Random ops with start noise while busy
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = rnd32();
      b = rnd32();
      issue(o, a, b, 1'b1, 1'b0, c);
      while (busy && cyc <= c + 30) begin
        start = ($urandom_range(0, 3) == 0);
        op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
        @(posedge clk); #1;
      end
      start = 1'b0;
      drain();
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
